multicycle_ctrl: RTL and testbench

//  Multicycle FSM controller for the RV32 datapath. Sequences fetch, decode, execute, memory and writeback over

---
 rtl/multicycle_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_alu_decoder.sv | 22 ++
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcodes, ALU codes, mux codes and FSM states for the multicycle controller
package multicycle_ctrl_pkg;

  // RV32 opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_TIPOR  = 7'b0110011;
  localparam logic [6:0] OP_TIPOI  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JUMP   = 7'b1101111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [6:0] FUNCT7_SUB     = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // PC source select
  localparam logic [1:0] PC4   = 2'd0;
  localparam logic [1:0] PCBEQ = 2'd1;
  localparam logic [1:0] PCIMM = 2'd2;

  // Register-file write data select
  localparam logic [1:0] ORIG_ALU = 2'd0;
  localparam logic [1:0] ORIG_MEM = 2'd1;
  localparam logic [1:0] ORIG_PC4 = 2'd2;

  // ALU B operand select
  localparam logic [1:0] ALUB_RS2   = 2'd0;
  localparam logic [1:0] ALUB_CONST = 2'd1;
  localparam logic [1:0] ALUB_IMM   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - funct3/funct7 to ALU operation for R-type execute
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_ctrl_o
);

  // funct7 only distinguishes SUB from ADD; unsupported funct3 values fall back to ADD
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (funct3_i)
      FUNCT3_ADD_SUB: alu_ctrl_o = (funct7_i == FUNCT7_SUB) ? ALU_SUB : ALU_ADD;
      FUNCT3_SLT:     alu_ctrl_o = ALU_SLT;
      FUNCT3_OR:      alu_ctrl_o = ALU_OR;
      FUNCT3_AND:     alu_ctrl_o = ALU_AND;
      default:        alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32 control FSM; ILLEGAL_TRAP_EN adds a TRAP state and illegal_instr port
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         OrigPC,
  output logic               OrigALUA,
  output logic [1:0]         OrigALUB,
  output logic [3:0]         ALUControl,
  output logic [1:0]         OrigWriteData,
  output logic               RegWrite,
  output logic               instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal_instr,
`endif
  output logic [STATE_W-1:0] dbg_state
);

  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [3:0] alu_r;
  logic       known_op;

  assign opcode = instruction[6:0];

  // zero is qualified with PCWriteCond in the datapath; register/immediate fields are datapath-only
  logic unused_inputs;
  assign unused_inputs = ^{zero, instruction[24:15], instruction[11:7]};

  assign known_op = (opcode == OP_LOAD)  || (opcode == OP_STORE)  ||
                    (opcode == OP_TIPOR) || (opcode == OP_TIPOI)  ||
                    (opcode == OP_BRANCH)|| (opcode == OP_JUMP);

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .funct3_i   (instruction[14:12]),
    .funct7_i   (instruction[31:25]),
    .alu_ctrl_o (alu_r)
  );

  // State register; reset wins over any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state: memory states stall on mem_ready, DECODE dispatches on opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_TIPOR:          state_d = S_EXEC_R;
          OP_TIPOI:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JUMP:           state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R,
      S_EXEC_I:   state_d = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BEQ,
      S_JAL:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs: state-decoded, all idle while reset is high so no write or strobe escapes
  always_comb begin
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    OrigPC        = PC4;
    OrigALUA      = 1'b0;
    OrigALUB      = ALUB_RS2;
    ALUControl    = ALU_ADD;
    OrigWriteData = ORIG_ALU;
    RegWrite      = 1'b0;
    instr_done    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead  = 1'b1;
          OrigALUB = ALUB_CONST;
          IRWrite  = mem_ready;
          PCWrite  = mem_ready;
          OrigPC   = PC4;
        end
        S_DECODE: begin
          OrigALUB = ALUB_IMM;
`ifndef ILLEGAL_TRAP_EN
          instr_done = !known_op;
`endif
        end
        S_MEM_ADDR: begin
          OrigALUA = 1'b1;
          OrigALUB = ALUB_IMM;
        end
        S_MEM_RD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite      = 1'b1;
          OrigWriteData = ORIG_MEM;
          instr_done    = 1'b1;
        end
        S_MEM_WR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          OrigALUA   = 1'b1;
          OrigALUB   = ALUB_RS2;
          ALUControl = alu_r;
        end
        S_EXEC_I: begin
          OrigALUA = 1'b1;
          OrigALUB = ALUB_IMM;
        end
        S_ALU_WB: begin
          RegWrite      = 1'b1;
          OrigWriteData = ORIG_ALU;
          instr_done    = 1'b1;
        end
        S_BEQ: begin
          OrigALUA    = 1'b1;
          OrigALUB    = ALUB_RS2;
          ALUControl  = ALU_SUB;
          PCWriteCond = 1'b1;
          OrigPC      = PCBEQ;
          instr_done  = 1'b1;
        end
        S_JAL: begin
          RegWrite      = 1'b1;
          OrigWriteData = ORIG_PC4;
          PCWrite       = 1'b1;
          OrigPC        = PCIMM;
          instr_done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = !reset && (state_q == S_TRAP);
`else
  logic unused_known_op;
  assign unused_known_op = known_op;
`endif

  assign dbg_state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic [1:0]  OrigPC, OrigALUB, OrigWriteData;
  logic        OrigALUA, RegWrite, instr_done;
  logic [3:0]  ALUControl;
  logic [3:0]  dbg_state;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_instr;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string name;
    int lat;   int rw;  int rwd; int wd;  int alu3;
    int opc;   int pcw; int pcwc; int rd; int wr;
  } exp_t;

  exp_t sb[$];

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .OrigPC(OrigPC), .OrigALUA(OrigALUA), .OrigALUB(OrigALUB),
    .ALUControl(ALUControl), .OrigWriteData(OrigWriteData), .RegWrite(RegWrite),
    .instr_done(instr_done),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int lat, input int rw, input int rwd, input int wd,
                      input int alu3, input int opc, input int pcw, input int pcwc,
                      input int rd, input int wr);
    exp_t e;
    e.name = name; e.lat = lat; e.rw = rw; e.rwd = rwd; e.wd = wd; e.alu3 = alu3;
    e.opc = opc; e.pcw = pcw; e.pcwc = pcwc; e.rd = rd; e.wr = wr;
    sb.push_back(e);
  endtask

  // Drive one instruction for lat cycles; lowmask bit k holds mem_ready low in cycle k+1
  task automatic issue(input logic [31:0] ins, input int lat, input logic [15:0] lowmask);
    for (int k = 0; k < lat; k++) begin
      instruction = ins;
      mem_ready   = ~lowmask[k];
      @(posedge clk); #1;
    end
  endtask

  // Monitor: accumulate per-instruction activity, compare against the scoreboard on instr_done
  int mcyc = 0, mrw = 0, mrd = 0, mwr = 0;
  logic [3:0] malu3 = A_ADD;
  always @(negedge clk) begin
    if (reset) begin
      mcyc = 0; mrw = 0; mrd = 0; mwr = 0; malu3 = A_ADD;
    end else begin
      mcyc++;
      if (RegWrite) mrw++;
      if (MemRead && IorD) mrd++;
      if (MemWrite) mwr++;
      if (mcyc == 3) malu3 = ALUControl;
      chk("mem_excl", int'(MemRead && MemWrite), 0);
      if (instr_done) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_lat"},    mcyc, e.lat);
          chk({e.name, "_rw"},     mrw, e.rw);
          chk({e.name, "_rwd"},    int'(RegWrite), e.rwd);
          chk({e.name, "_wd"},     int'(OrigWriteData), e.wd);
          chk({e.name, "_alu3"},   int'(malu3), e.alu3);
          chk({e.name, "_origpc"}, int'(OrigPC), e.opc);
          chk({e.name, "_pcw"},    int'(PCWrite), e.pcw);
          chk({e.name, "_pcwc"},   int'(PCWriteCond), e.pcwc);
          chk({e.name, "_rdcyc"},  mrd, e.rd);
          chk({e.name, "_wrcyc"},  mwr, e.wr);
        end
        mcyc = 0; mrw = 0; mrd = 0; mwr = 0; malu3 = A_ADD;
      end
    end
  end

  initial begin
    #100000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1; instruction = 32'h0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state",    int'(dbg_state), 0);
    chk("rst_memread",  int'(MemRead), 0);
    chk("rst_pcwrite",  int'(PCWrite), 0);
    chk("rst_irwrite",  int'(IRWrite), 0);
    chk("rst_alub",     int'(OrigALUB), 0);
    chk("rst_aluctl",   int'(ALUControl), int'(A_ADD));
    chk("rst_done",     int'(instr_done), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    //   name   lat rw rwd wd alu3          opc pcw pcwc rd wr
    push("add",   4, 1, 1, 0, int'(A_ADD),  0, 0, 0, 0, 0); issue(32'h002081B3, 4, 16'h0);
    push("sub",   4, 1, 1, 0, int'(A_SUB),  0, 0, 0, 0, 0); issue(32'h402081B3, 4, 16'h0);
    push("or",    4, 1, 1, 0, int'(A_OR),   0, 0, 0, 0, 0); issue(32'h0020E1B3, 4, 16'h0);
    push("and",   4, 1, 1, 0, int'(A_AND),  0, 0, 0, 0, 0); issue(32'h0020F1B3, 4, 16'h0);
    push("slt",   4, 1, 1, 0, int'(A_SLT),  0, 0, 0, 0, 0); issue(32'h0020A1B3, 4, 16'h0);
    push("sll",   4, 1, 1, 0, int'(A_ADD),  0, 0, 0, 0, 0); issue(32'h002091B3, 4, 16'h0);
    push("and7",  4, 1, 1, 0, int'(A_AND),  0, 0, 0, 0, 0); issue(32'h4020F1B3, 4, 16'h0);
    push("addi",  4, 1, 1, 0, int'(A_ADD),  0, 0, 0, 0, 0); issue(32'h00500093, 4, 16'h0);
    push("fstall",6, 1, 1, 0, int'(A_ADD),  0, 0, 0, 0, 0); issue(32'h002081B3, 6, 16'h0003);
    push("lw",    8, 1, 1, 1, int'(A_ADD),  0, 0, 0, 4, 0); issue(32'h0000A283, 8, 16'h0038);
    push("sw",    4, 0, 0, 0, int'(A_ADD),  0, 0, 0, 0, 1); issue(32'h0050A223, 4, 16'h0);
    push("beq",   3, 0, 0, 0, int'(A_SUB),  1, 0, 1, 0, 0); issue(32'h00208463, 3, 16'h0);
    push("jal",   3, 1, 1, 2, int'(A_ADD),  2, 1, 0, 0, 0); issue(32'h010000EF, 3, 16'h0);

    // Store stalled in MEM_WR, then reset arrives together with mem_ready
    issue(32'h0050A223, 4, 16'h0008);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("wr_hold_memwrite", int'(MemWrite), 1);
    chk("wr_hold_iord",     int'(IorD), 1);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("wr_rst_memwrite", int'(MemWrite), 0);
    chk("wr_rst_done",     int'(instr_done), 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0; instruction = 32'h002081B3;
    @(negedge clk);
    chk("post_rst_state",    int'(dbg_state), 0);
    chk("post_rst_memwrite", int'(MemWrite), 0);
    chk("post_rst_regwrite", int'(RegWrite), 0);
    chk("post_rst_done",     int'(instr_done), 0);
    chk("post_rst_memread",  int'(MemRead), 1);
    @(posedge clk); #1;
    // one FETCH stall cycle already spent above, so five cycles in total
    push("add_after_rst", 5, 1, 1, 0, int'(A_ADD), 0, 0, 0, 0, 0); issue(32'h002081B3, 4, 16'h0);

`ifdef ILLEGAL_TRAP_EN
    issue(32'h0000007F, 2, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("trap_illegal",  int'(illegal_instr), 1);
      chk("trap_state",    int'(dbg_state), 11);
      chk("trap_memread",  int'(MemRead), 0);
      chk("trap_done",     int'(instr_done), 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("trap_rst_illegal", int'(illegal_instr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
`else
    push("nop",   2, 0, 0, 0, int'(A_ADD),  0, 0, 0, 0, 0); issue(32'h0000007F, 2, 16'h0);
`endif
    push("add_end", 4, 1, 1, 0, int'(A_ADD), 0, 0, 0, 0, 0); issue(32'h002081B3, 4, 16'h0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
